// File: rtl/arb_2m1s_pkg.sv
`default_nettype none
// ============================================================================
// Module : arb_2m1s_pkg
// Brief  : Shared types and master-ID constants for the 2-master arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package arb_2m1s_pkg;

    typedef logic [0:0] arb_mid_t;

    localparam arb_mid_t ARB_M0 = 1'b0;
    localparam arb_mid_t ARB_M1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/arb_2m1s_if.sv
`default_nettype none
// ============================================================================
// Module : MemSplit32
// Brief  : 32-bit req/ack memory bus with in-order read responses.
// Rev    : 1.0  initial release
// ============================================================================
interface MemSplit32;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;

    modport Master (
        output req, we, addr, be, wdata,
        input  ack, resp, rdata
    );

    modport Slave (
        input  req, we, addr, be, wdata,
        output ack, resp, rdata
    );

endinterface
`default_nettype wire

// File: rtl/arb_id_fifo.sv
`default_nettype none
// ============================================================================
// Module : arb_id_fifo
// Brief  : In-order FIFO of master IDs for reads awaiting a slave response.
// Rev    : 1.0  initial release
// ============================================================================
module arb_id_fifo
    import arb_2m1s_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = arb_mid_t
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic                       pop,
    input  T                           din,
    output T                           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    T                 r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; only entries between the pointers are meaningful.
    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/arb_2m1s.sv
`default_nettype none
// ============================================================================
// Module : arb_2m1s
// Brief  : Round-robin 2-master/1-slave MemSplit32 arbiter with read routing.
// Rev    : 1.0  initial release
// ============================================================================
module arb_2m1s
    import arb_2m1s_pkg::*;
#(
    parameter int RESP_DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    MemSplit32.Slave  m0,
    MemSplit32.Slave  m1,
    MemSplit32.Master s,
    output logic      resp_err_o
);

    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    logic        r_lock;
    arb_mid_t    r_lock_id;
    arb_mid_t    r_last_served;

    arb_mid_t    w_owner;
    arb_mid_t    w_head;
    logic        w_owner_req;
    logic        w_owner_we;
    logic [31:0] w_owner_addr;
    logic [3:0]  w_owner_be;
    logic [31:0] w_owner_wdata;
    logic        w_rd_block;
    logic        w_fwd;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic        w_resp_valid;
    logic [CNT_W-1:0] w_fifo_count;

    always_comb begin
        w_owner = ARB_M0;
        if (r_lock) begin
            w_owner = r_lock_id;
        end else if (m0.req && m1.req) begin
            w_owner = ~r_last_served;
        end else if (m1.req) begin
            w_owner = ARB_M1;
        end
    end

    always_comb begin
        w_owner_req   = m0.req;
        w_owner_we    = m0.we;
        w_owner_addr  = m0.addr;
        w_owner_be    = m0.be;
        w_owner_wdata = m0.wdata;
        if (w_owner == ARB_M1) begin
            w_owner_req   = m1.req;
            w_owner_we    = m1.we;
            w_owner_addr  = m1.addr;
            w_owner_be    = m1.be;
            w_owner_wdata = m1.wdata;
        end
    end

    // Full is judged on the registered count, so a same-cycle pop never lets a read through.
    assign w_rd_block = w_owner_req && !w_owner_we && w_full;
    // Reset forces the whole forward path quiet even while masters keep requesting.
    assign w_fwd      = rst_i && w_owner_req && !w_rd_block;

    assign s.req   = w_fwd;
    assign s.we    = w_fwd && w_owner_we;
    assign s.addr  = w_fwd ? w_owner_addr  : '0;
    assign s.be    = w_fwd ? w_owner_be    : '0;
    assign s.wdata = w_fwd ? w_owner_wdata : '0;

    assign m0.ack = w_fwd && s.ack && (w_owner == ARB_M0);
    assign m1.ack = w_fwd && s.ack && (w_owner == ARB_M1);

    assign w_push       = w_fwd && s.ack && !w_owner_we;
    assign w_pop        = s.resp && !w_empty;
    assign w_resp_valid = (w_fifo_count != '0);

    assign m0.resp  = w_resp_valid && (w_head == ARB_M0) && s.resp;
    assign m1.resp  = w_resp_valid && (w_head == ARB_M1) && s.resp;
    assign m0.rdata = (w_resp_valid && (w_head == ARB_M0)) ? s.rdata : '0;
    assign m1.rdata = (w_resp_valid && (w_head == ARB_M1)) ? s.rdata : '0;

    arb_id_fifo #(
        .DEPTH (RESP_DEPTH),
        .T     (arb_mid_t)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_owner),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_fifo_count)
    );

    // Lock holds the owner while its request waits for ack, or while a read is stalled on full.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_lock        <= 1'b0;
            r_lock_id     <= ARB_M0;
            r_last_served <= ARB_M1;
            resp_err_o    <= 1'b0;
        end else begin
            r_lock    <= w_fwd ? !s.ack : w_rd_block;
            r_lock_id <= w_owner;
            if (w_fwd && s.ack) r_last_served <= w_owner;
            if (s.resp && w_empty) resp_err_o <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arb_2m1s.sv
`default_nettype none
// ============================================================================
// Module : tb_arb_2m1s
// Brief  : Directed and randomized self-checking bench for arb_2m1s.
// Rev    : 1.0  initial release
// ============================================================================
module tb_arb_2m1s;

    logic clk   = 1'b0;
    logic rst_i = 1'b0;
    logic resp_err_o;
    int   errors = 0;
    int   checks = 0;

    MemSplit32 m0_if ();
    MemSplit32 m1_if ();
    MemSplit32 s_if ();

    arb_2m1s #(.RESP_DEPTH(4)) u_dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .m0         (m0_if),
        .m1         (m1_if),
        .s          (s_if),
        .resp_err_o (resp_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [138:0] outs_vec();
        return {s_if.req, s_if.we, s_if.addr, s_if.be, s_if.wdata,
                m0_if.ack, m0_if.resp, m0_if.rdata,
                m1_if.ack, m1_if.resp, m1_if.rdata, resp_err_o};
    endfunction

    task automatic set_m(input int id, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (id == 0) begin
            m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.be = 4'hF; m0_if.wdata = wdata;
        end else begin
            m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.be = 4'hF; m1_if.wdata = wdata;
        end
    endtask

    task automatic set_s(input logic ack, input logic resp, input logic [31:0] rdata);
        s_if.ack = ack; s_if.resp = resp; s_if.rdata = rdata;
    endtask

    task automatic idle_inputs();
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
        set_s(1'b0, 1'b0, 32'h0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        set_m(0, 1'b1, 1'b1, 32'h1111_0000, 32'hAAAA_5555);
        set_m(1, 1'b1, 1'b0, 32'h2222_0000, 32'h0);
        set_s(1'b1, 1'b1, 32'h1234_5678);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (outs_vec() !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", outs_vec());
        end
        checks++;
        if (u_dut.w_fifo_count !== 3'd0) begin
            errors++; $display("FAIL reset_count: got %0d expected 0", u_dut.w_fifo_count);
        end
        apply_reset();
    endtask

    task automatic test_alternate();
        logic [31:0] rd [4];
        rd[0] = 32'hA; rd[1] = 32'hB; rd[2] = 32'hC; rd[3] = 32'hD;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_m(0, 1'b1, 1'b0, 32'h1000, 32'h0);
            set_m(1, 1'b1, 1'b0, 32'h2000, 32'h0);
            set_s(1'b1, 1'b0, 32'h0);
            #1;
            checks++;
            if ({m0_if.ack, m1_if.ack} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL alt_grant[%0d]: got m0/m1 ack %b%b", k, m0_if.ack, m1_if.ack);
            end
            checks++;
            if (s_if.addr !== ((k % 2 == 0) ? 32'h1000 : 32'h2000)) begin
                errors++; $display("FAIL alt_addr[%0d]: got %h", k, s_if.addr);
            end
        end
        @(negedge clk);
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_s(1'b0, 1'b1, rd[k]);
            #1;
            checks++;
            if ({m0_if.resp, m1_if.resp} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL alt_resp[%0d]: got m0/m1 resp %b%b", k, m0_if.resp, m1_if.resp);
            end
            checks++;
            if (((k % 2 == 0) ? m0_if.rdata : m1_if.rdata) !== rd[k] ||
                ((k % 2 == 0) ? m1_if.rdata : m0_if.rdata) !== 32'h0) begin
                errors++; $display("FAIL alt_rdata[%0d]: got m0 %h m1 %h expected %h to m%0d", k,
                                   m0_if.rdata, m1_if.rdata, rd[k], k % 2);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_write();
        apply_reset();
        @(negedge clk);
        set_m(0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF);
        set_s(1'b1, 1'b0, 32'h0);
        #1;
        checks++;
        if ({s_if.req, s_if.we, s_if.addr, s_if.wdata} !== {1'b1, 1'b1, 32'h100, 32'hDEADBEEF}) begin
            errors++; $display("FAIL wr_fwd: got req=%b we=%b addr=%h wdata=%h", s_if.req, s_if.we, s_if.addr, s_if.wdata);
        end
        checks++;
        if ({m0_if.ack, m1_if.ack} !== 2'b10) begin
            errors++; $display("FAIL wr_ack: got m0/m1 ack %b%b expected 10", m0_if.ack, m1_if.ack);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (u_dut.w_fifo_count !== 3'd0) begin
            errors++; $display("FAIL wr_count: got %0d expected 0", u_dut.w_fifo_count);
        end
    endtask

    task automatic test_hold_lock();
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_m(1, 1'b1, 1'b0, 32'h200, 32'h0);
            if (k >= 1) set_m(0, 1'b1, 1'b0, 32'h300, 32'h0);
            set_s(1'b0, 1'b0, 32'h0);
            #1;
            checks++;
            if ({s_if.req, s_if.addr, m0_if.ack, m1_if.ack} !== {1'b1, 32'h200, 2'b00}) begin
                errors++; $display("FAIL lock_hold[%0d]: got req=%b addr=%h acks=%b%b", k,
                                   s_if.req, s_if.addr, m0_if.ack, m1_if.ack);
            end
        end
        @(negedge clk);
        set_s(1'b1, 1'b0, 32'h0);
        #1;
        checks++;
        if ({s_if.addr, m0_if.ack, m1_if.ack} !== {32'h200, 2'b01}) begin
            errors++; $display("FAIL lock_release: got addr=%h acks=%b%b", s_if.addr, m0_if.ack, m1_if.ack);
        end
        @(negedge clk);
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checks++;
        if ({s_if.addr, m0_if.ack, m1_if.ack} !== {32'h300, 2'b10}) begin
            errors++; $display("FAIL lock_next: got addr=%h acks=%b%b", s_if.addr, m0_if.ack, m1_if.ack);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_full_stall();
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_m(0, 1'b1, 1'b0, 32'h40 + 32'(4 * k), 32'h0);
            set_s(1'b1, 1'b0, 32'h0);
            #1;
            checks++;
            if (m0_if.ack !== 1'b1) begin
                errors++; $display("FAIL fill_ack[%0d]: got %b expected 1", k, m0_if.ack);
            end
        end
        @(negedge clk);
        set_m(0, 1'b1, 1'b0, 32'h50, 32'h0);
        #1;
        checks++;
        if ({s_if.req, m0_if.ack} !== 2'b00) begin
            errors++; $display("FAIL full_block: got req=%b ack=%b expected 00", s_if.req, m0_if.ack);
        end
        @(negedge clk);
        set_s(1'b1, 1'b1, 32'h11);
        #1;
        checks++;
        if ({s_if.req, m0_if.resp, m0_if.rdata} !== {1'b0, 1'b1, 32'h11}) begin
            errors++; $display("FAIL full_pop_cycle: got req=%b resp=%b rdata=%h", s_if.req, m0_if.resp, m0_if.rdata);
        end
        @(negedge clk);
        set_s(1'b1, 1'b0, 32'h0);
        #1;
        checks++;
        if ({s_if.req, s_if.addr, m0_if.ack} !== {1'b1, 32'h50, 1'b1}) begin
            errors++; $display("FAIL full_resume: got req=%b addr=%h ack=%b", s_if.req, s_if.addr, m0_if.ack);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_spurious_resp();
        apply_reset();
        @(negedge clk);
        set_s(1'b0, 1'b1, 32'h55);
        #1;
        checks++;
        if ({m0_if.resp, m1_if.resp, resp_err_o} !== 3'b000) begin
            errors++; $display("FAIL spur_drop: got m0/m1 resp=%b%b err=%b", m0_if.resp, m1_if.resp, resp_err_o);
        end
        @(negedge clk);
        set_s(1'b0, 1'b0, 32'h0);
        #1;
        checks++;
        if (resp_err_o !== 1'b1) begin
            errors++; $display("FAIL spur_err_set: got %b expected 1", resp_err_o);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (resp_err_o !== 1'b1) begin
            errors++; $display("FAIL spur_err_sticky: got %b expected 1", resp_err_o);
        end
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        checks++;
        if (resp_err_o !== 1'b0) begin
            errors++; $display("FAIL spur_err_clear: got %b expected 0", resp_err_o);
        end
        @(negedge clk);
        rst_i = 1'b1;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            set_m(0, 1'b1, 1'b0, 32'h600 + 32'(k), 32'h0);
            set_s(1'b1, 1'b0, 32'h0);
        end
        @(negedge clk);
        set_m(0, 1'b1, 1'b1, 32'h700, 32'h9);
        set_m(1, 1'b1, 1'b1, 32'h800, 32'h8);
        set_s(1'b1, 1'b1, 32'h77);
        rst_i = 1'b0;
        #1;
        checks++;
        if (outs_vec() !== '0) begin
            errors++; $display("FAIL midrst_outputs: got %h expected 0", outs_vec());
        end
        @(negedge clk);
        rst_i = 1'b1;
        idle_inputs();
        set_s(1'b0, 1'b1, 32'h66);
        #1;
        checks++;
        if ({u_dut.w_fifo_count, m0_if.resp, m1_if.resp} !== {3'd0, 2'b00}) begin
            errors++; $display("FAIL midrst_flush: got count=%0d resp=%b%b", u_dut.w_fifo_count, m0_if.resp, m1_if.resp);
        end
        @(negedge clk);
        set_s(1'b0, 1'b0, 32'h0);
        set_m(0, 1'b1, 1'b0, 32'hA00, 32'h0);
        set_m(1, 1'b1, 1'b0, 32'hB00, 32'h0);
        #1;
        checks++;
        if (resp_err_o !== 1'b1) begin
            errors++; $display("FAIL midrst_late_resp: got err=%b expected 1", resp_err_o);
        end
        checks++;
        if ({s_if.req, s_if.addr} !== {1'b1, 32'hA00}) begin
            errors++; $display("FAIL midrst_first_tie: got req=%b addr=%h expected m0", s_if.req, s_if.addr);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_random();
        int          q [$];
        int          hold;
        int          last;
        int          owner;
        logic        mreq [2];
        logic        mwe  [2];
        logic [31:0] maddr [2];
        logic [31:0] mwd   [2];
        logic        sack, sresp, exp_fwd;
        logic [31:0] srdata;
        logic [1:0]  exp_resp;

        apply_reset();
        hold = -1;
        last = 1;
        for (int i = 0; i < 2; i++) begin
            mreq[i] = 1'b0; mwe[i] = 1'b0; maddr[i] = '0; mwd[i] = '0;
        end
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!mreq[i] && ($urandom_range(0, 1) == 1)) begin
                    mreq[i]  = 1'b1;
                    mwe[i]   = ($urandom_range(0, 2) == 0);
                    maddr[i] = $urandom;
                    mwd[i]   = $urandom;
                end
                set_m(i, mreq[i], mwe[i], maddr[i], mwd[i]);
            end
            sack   = ($urandom_range(0, 1) == 1);
            sresp  = (q.size() > 0) && ($urandom_range(0, 2) == 0);
            srdata = $urandom;
            set_s(sack, sresp, srdata);
            #1;

            if (hold >= 0)              owner = hold;
            else if (mreq[0] && mreq[1]) owner = 1 - last;
            else if (mreq[1])            owner = 1;
            else                         owner = 0;
            exp_fwd = mreq[owner] && !(!mwe[owner] && q.size() == 4);

            checks++;
            if (s_if.req !== exp_fwd) begin
                errors++; $display("FAIL rnd_req[%0d]: got %b expected %b", cyc, s_if.req, exp_fwd);
            end
            if (exp_fwd) begin
                checks++;
                if ({s_if.we, s_if.addr, s_if.wdata} !== {mwe[owner], maddr[owner], mwd[owner]}) begin
                    errors++; $display("FAIL rnd_fwd[%0d]: got we=%b addr=%h wdata=%h expected m%0d %b %h %h", cyc,
                                       s_if.we, s_if.addr, s_if.wdata, owner, mwe[owner], maddr[owner], mwd[owner]);
                end
            end
            checks++;
            if ({m0_if.ack, m1_if.ack} !== {exp_fwd && sack && owner == 0, exp_fwd && sack && owner == 1}) begin
                errors++; $display("FAIL rnd_ack[%0d]: got %b%b owner m%0d fwd=%b sack=%b", cyc,
                                   m0_if.ack, m1_if.ack, owner, exp_fwd, sack);
            end
            if (sresp) begin
                exp_resp = (q[0] == 0) ? 2'b10 : 2'b01;
                checks++;
                if ({m0_if.resp, m1_if.resp} !== exp_resp ||
                    ((q[0] == 0) ? m0_if.rdata : m1_if.rdata) !== srdata) begin
                    errors++; $display("FAIL rnd_resp[%0d]: got resp=%b%b rdata=%h/%h expected m%0d %h", cyc,
                                       m0_if.resp, m1_if.resp, m0_if.rdata, m1_if.rdata, q[0], srdata);
                end
                void'(q.pop_front());
            end

            if (exp_fwd && sack) begin
                last = owner;
                hold = -1;
                if (!mwe[owner]) q.push_back(owner);
                mreq[owner] = 1'b0;
            end else if (mreq[owner]) begin
                hold = owner;
            end else begin
                hold = -1;
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (resp_err_o !== 1'b0) begin
            errors++; $display("FAIL rnd_no_err: got %b expected 0", resp_err_o);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_alternate();
        test_write();
        test_hold_lock();
        test_full_stall();
        test_spurious_resp();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
